// File: rtl/bloom_row_rmw_ctrl_if.sv
// Request/response bus of the Bloom row read-modify-write controller.
//   req_valid/req_ready : request handshake, accepted when both are high on clk
//   req_op              : 0 = lookup, 1 = insert
//   req_row/req_bit     : row address and bit index inside a bucket
//   rsp_valid           : one-cycle response strobe (no backpressure)
//   rsp_hit/rsp_row     : hit flag and row of the response
// The master modport is the requester; the slave modport is the controller.
interface bloom_row_rmw_ctrl_if #(
    parameter int ROW_BITS  = 8,
    parameter int BIT_IDX_W = 2
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_op;
    logic [ROW_BITS-1:0]  req_row;
    logic [BIT_IDX_W-1:0] req_bit;
    logic                 rsp_valid;
    logic                 rsp_hit;
    logic [ROW_BITS-1:0]  rsp_row;

    modport master (
        output req_valid, req_op, req_row, req_bit,
        input  req_ready, rsp_valid, rsp_hit, rsp_row
    );

    modport slave (
        input  req_valid, req_op, req_row, req_bit,
        output req_ready, rsp_valid, rsp_hit, rsp_row
    );
endinterface

// File: rtl/bloom_row_rmw_ctrl.sv
// Read-modify-write controller for the time-decaying Bloom filter row memory.
// Owns the row RAM and the bucket/loop timebase. Every request reads its row,
// hands it to the external aging stage together with a timebase snapshot,
// takes the aged row back, optionally sets the requested bit in the newest
// (MSB) bucket, writes the row back and reports whether the bit was set in
// any live bucket.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : request/response handshake
//   busy_init       : high while the clear sweep runs
//   upd_data        : raw row to the aging stage (zero outside the update cycle)
//   upd_cur_bucket  : bucket snapshot taken at request acceptance
//   upd_cur_loop    : loop snapshot taken at request acceptance
//   upd_result      : aged row returned combinationally by the aging stage
module bloom_row_rmw_ctrl #(
    parameter int DATA_WIDTH     = 72,
    parameter int NUM_BUCKETS    = 14,
    parameter int BUCKET_SZ      = 4,
    parameter int BITS_SHIFT     = 4,
    parameter int BLOOM_INIT_POS = 16,
    parameter int NUM_ROWS       = 256,
    parameter int ROW_BITS       = 8,
    parameter int BIT_IDX_W      = 2,
    parameter int BUCKET_PERIOD  = 1000
) (
    input  logic                                   clk,
    input  logic                                   reset,
    bloom_row_rmw_ctrl_if.slave                    bus,
    output logic                                   busy_init,
    output logic [DATA_WIDTH-1:0]                  upd_data,
    output logic [BITS_SHIFT-1:0]                  upd_cur_bucket,
    output logic [BLOOM_INIT_POS-BITS_SHIFT-1:0]   upd_cur_loop,
    input  logic [DATA_WIDTH-1:0]                  upd_result
);
    localparam int LOOP_W     = BLOOM_INIT_POS - BITS_SHIFT;
    localparam int TICK_W     = (BUCKET_PERIOD > 1) ? $clog2(BUCKET_PERIOD) : 1;
    localparam int NEWEST_POS = DATA_WIDTH - BUCKET_SZ;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_READ  = 3'd2,
        S_UPD   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                 state_r;
    logic [TICK_W-1:0]      tick_cnt_r;
    logic [BITS_SHIFT-1:0]  cur_bucket_r;
    logic [LOOP_W-1:0]      cur_loop_r;
    logic [ROW_BITS-1:0]    init_addr_r;
    logic                   clear_pending_r;
    logic                   busy_init_r;
    logic                   req_ready_r;
    logic                   rsp_valid_r;
    logic                   rsp_hit_r;
    logic [ROW_BITS-1:0]    rsp_row_r;
    logic                   op_r;
    logic [ROW_BITS-1:0]    row_r;
    logic [BIT_IDX_W-1:0]   bit_r;
    logic [BITS_SHIFT-1:0]  upd_cur_bucket_r;
    logic [LOOP_W-1:0]      upd_cur_loop_r;
    logic [DATA_WIDTH-1:0]  new_row_r;
    logic [DATA_WIDTH-1:0]  rd_data_r;
    logic [DATA_WIDTH-1:0]  mem_r [NUM_ROWS];

    logic                   tick_wrap_s;
    logic                   bucket_wrap_s;
    logic                   loop_wrap_s;
    logic                   leave_to_init_s;
    logic                   clear_pending_n_s;
    logic                   hit_s;
    logic [DATA_WIDTH-1:0]  new_row_s;
    logic                   ram_we_s;
    logic [ROW_BITS-1:0]    ram_waddr_s;
    logic [DATA_WIDTH-1:0]  ram_wdata_s;

    assign tick_wrap_s   = (tick_cnt_r == TICK_W'(BUCKET_PERIOD - 1));
    assign bucket_wrap_s = tick_wrap_s && (cur_bucket_r == BITS_SHIFT'(NUM_BUCKETS - 1));
    assign loop_wrap_s   = bucket_wrap_s && (cur_loop_r == {LOOP_W{1'b1}});

    // A wrap seen while sweeping (or on the cycle the sweep is launched) is
    // already covered by that sweep: no row is touched until it finishes.
    assign leave_to_init_s   = (state_r == S_IDLE) && clear_pending_r;
    assign clear_pending_n_s = !leave_to_init_s && (state_r != S_INIT) &&
                               (clear_pending_r || loop_wrap_s);

    // Bucket/loop timebase: free-running in every state, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r   <= '0;
            cur_bucket_r <= '0;
            cur_loop_r   <= '0;
        end else if (tick_wrap_s) begin
            tick_cnt_r <= '0;
            if (bucket_wrap_s) begin
                cur_bucket_r <= '0;
                cur_loop_r   <= cur_loop_r + LOOP_W'(1);
            end else begin
                cur_bucket_r <= cur_bucket_r + BITS_SHIFT'(1);
            end
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Hit detection over all live buckets and insertion into the newest bucket.
    always_comb begin
        hit_s = 1'b0;
        for (int k = 0; k < NUM_BUCKETS; k++) begin
            hit_s = hit_s | upd_result[BLOOM_INIT_POS + k * BUCKET_SZ + int'(bit_r)];
        end
        new_row_s = upd_result;
        if (op_r) begin
            new_row_s[NEWEST_POS + int'(bit_r)] = 1'b1;
        end else begin
            new_row_s = upd_result;
        end
    end

    // Control FSM with registered handshake, response and snapshot outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= S_INIT;
            init_addr_r      <= '0;
            clear_pending_r  <= 1'b0;
            busy_init_r      <= 1'b1;
            req_ready_r      <= 1'b0;
            rsp_valid_r      <= 1'b0;
            rsp_hit_r        <= 1'b0;
            rsp_row_r        <= '0;
            op_r             <= 1'b0;
            row_r            <= '0;
            bit_r            <= '0;
            upd_cur_bucket_r <= '0;
            upd_cur_loop_r   <= '0;
            new_row_r        <= '0;
        end else begin
            clear_pending_r <= clear_pending_n_s;
            rsp_valid_r     <= 1'b0;
            case (state_r)
                S_INIT: begin
                    init_addr_r <= init_addr_r + ROW_BITS'(1);
                    if (init_addr_r == ROW_BITS'(NUM_ROWS - 1)) begin
                        state_r     <= S_IDLE;
                        busy_init_r <= 1'b0;
                        req_ready_r <= !clear_pending_n_s;
                    end else begin
                        busy_init_r <= 1'b1;
                        req_ready_r <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (clear_pending_r) begin
                        state_r     <= S_INIT;
                        init_addr_r <= '0;
                        busy_init_r <= 1'b1;
                        req_ready_r <= 1'b0;
                    end else if (bus.req_valid && req_ready_r) begin
                        state_r          <= S_READ;
                        req_ready_r      <= 1'b0;
                        op_r             <= bus.req_op;
                        row_r            <= bus.req_row;
                        bit_r            <= bus.req_bit;
                        upd_cur_bucket_r <= cur_bucket_r;
                        upd_cur_loop_r   <= cur_loop_r;
                    end else begin
                        req_ready_r <= !clear_pending_n_s;
                    end
                end
                S_READ: begin
                    state_r <= S_UPD;
                end
                S_UPD: begin
                    state_r     <= S_WRITE;
                    new_row_r   <= new_row_s;
                    rsp_hit_r   <= hit_s;
                    rsp_row_r   <= row_r;
                    rsp_valid_r <= 1'b1;
                end
                S_WRITE: begin
                    state_r     <= S_IDLE;
                    req_ready_r <= !clear_pending_n_s;
                end
                default: begin
                    state_r     <= S_INIT;
                    init_addr_r <= '0;
                    busy_init_r <= 1'b1;
                    req_ready_r <= 1'b0;
                end
            endcase
        end
    end

    // Lookups are written back too, so the aging applied downstream persists.
    assign ram_we_s    = !reset && ((state_r == S_INIT) || (state_r == S_WRITE));
    assign ram_waddr_s = (state_r == S_INIT) ? init_addr_r : row_r;
    assign ram_wdata_s = (state_r == S_INIT) ? '0 : new_row_r;

    // Row RAM with registered read port; contents are not reset, the sweep clears them.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_waddr_s] <= ram_wdata_s;
        end
        rd_data_r <= mem_r[row_r];
    end

    assign busy_init      = busy_init_r;
    assign bus.req_ready  = req_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_hit    = rsp_hit_r;
    assign bus.rsp_row    = rsp_row_r;
    assign upd_cur_bucket = upd_cur_bucket_r;
    assign upd_cur_loop   = upd_cur_loop_r;
    assign upd_data       = (state_r == S_UPD) ? rd_data_r : '0;
endmodule

// File: doc/bloom_row_rmw_ctrl.md
Name: bloom_row_rmw_ctrl

Overview:
Read-modify-write controller for the time-decaying Bloom filter row memory. It owns the row RAM and the bucket/loop timebase. Each request follows one path: fetch the row, send it to the downstream row-aging shift stage, then take the aged row back. For inserts it sets the requested bit in the newest bucket and writes the row back. It reports whether the bit was present in any live bucket.

Parameters:
DATA_WIDTH, 72, row width: bloom region [DATA_WIDTH-1:BLOOM_INIT_POS] plus header
NUM_BUCKETS, 14, buckets per row
BUCKET_SZ, 4, bits per bucket
BITS_SHIFT, 4, header bucket-index width, log2(NUM_BUCKETS)
BLOOM_INIT_POS, 16, header width; loop field is [BLOOM_INIT_POS-BITS_SHIFT-1:0], bucket field sits above it
NUM_ROWS, 256, rows in RAM
ROW_BITS, 8, log2(NUM_ROWS)
BIT_IDX_W, 2, log2(BUCKET_SZ)
BUCKET_PERIOD, 1000, clk cycles per bucket tick (minimum 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted on clk edge when req_valid && req_ready
req_op  in  1  0=lookup, 1=insert
req_row  in  ROW_BITS  row address
req_bit  in  BIT_IDX_W  bit index within bucket
rsp_valid  out  1  one-cycle response strobe, no backpressure
rsp_hit  out  1  requested bit set in aged row before modification
rsp_row  out  ROW_BITS  row of this response
busy_init  out  1  clear sweep in progress
upd_data  out  DATA_WIDTH  raw row to aging stage
upd_cur_bucket  out  BITS_SHIFT  snapshot bucket to aging stage
upd_cur_loop  out  BLOOM_INIT_POS-BITS_SHIFT  snapshot loop to aging stage
upd_result  in  DATA_WIDTH  aged row from aging stage (combinational return)

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_hit=0, rsp_row=0, busy_init=1, timebase counters=0, FSM=S_INIT, init address=0.
- Timebase: tick_cnt counts 0..BUCKET_PERIOD-1 and wraps. On wrap, cur_bucket increments. When cur_bucket is NUM_BUCKETS-1, it goes to 0 instead and cur_loop increments. The timebase runs in every state except reset.
- Loop wrap: when cur_loop goes from all-ones to 0, set clear_pending. At the next S_IDLE, clear_pending sends the FSM to S_INIT instead of accepting a request, and is then cleared. An in-flight transaction completes first.
- S_INIT: write zero to row init_addr and increment init_addr each cycle. After row NUM_ROWS-1, go to S_IDLE. busy_init=1 only in S_INIT. For reset, the sweep takes NUM_ROWS cycles.
- S_IDLE: req_ready=1 unless clear_pending. On acceptance, latch op, row and bit, and snapshot cur_bucket/cur_loop into the upd_cur_* registers. These hold for the whole transaction, so a tick mid-transaction has no effect on it. Go to S_READ.
- S_READ: drive the RAM read address; read data is registered. Go to S_UPD.
- S_UPD: upd_data = RAM data. Register upd_result and compute the following:
  - hit = OR over k of upd_result[BLOOM_INIT_POS + k*BUCKET_SZ + bit] for k in 0..NUM_BUCKETS-1.
  - new row = upd_result; if insert, also set bit [DATA_WIDTH-BUCKET_SZ+bit], i.e. the newest bucket is the MSB bucket.
  - Go to S_WRITE.
- S_WRITE: always write the new row back, lookup included, so aging is persisted. rsp_valid=1 with rsp_hit and rsp_row. Go to S_IDLE.
- Latency: acceptance edge = cycle 0; rsp_valid is high in cycle 3. Maximum throughput is one request per 4 cycles.
- upd_data is 0 outside S_UPD. The header written is whatever upd_result carries; no header arithmetic is done here.
- Reset asserted mid-transaction abandons the transaction with no response, then the full sweep runs.

Test Plan:
1. Reset high for 2 cycles, then release -> busy_init=1 and req_ready=0 for exactly 256 cycles, then req_ready=1. A lookup on row 0, bit 0 -> rsp_hit=0 in cycle 3.
2. Insert row 5, bit 2 at bucket 0, loop 0 -> rsp_hit=0, row 5 bit 70 set, header bucket=0, loop=0. A lookup on row 5, bit 2 -> hit=1; row 5, bit 1 -> hit=0; row 6, bit 2 -> hit=0.
3. Aging (BUCKET_PERIOD=4): insert row 5, bit 2, advance to bucket 13, loop 0 -> lookup hit=1 and stored bit 18 set. One more tick to bucket 0, loop 1 -> lookup hit=0, bloom region all zero, header bucket=0, loop=1.
4. req_valid held high with three inserts to rows 1, 2, 3 -> acceptances 4 cycles apart and rsp_valid in cycles 3, 7, 11 with matching rsp_row.
5. A tick landing in S_READ -> upd_cur_bucket still shows the pre-tick value through S_WRITE; the next request sees the new value.
6. BUCKET_PERIOD=1, BLOOM_INIT_POS=7 (loop width 3) -> after 8*14 ticks the loop wraps; busy_init rises after the in-flight response, and all rows read zero afterwards.
